// File: rtl/vdp_host_if.sv
// CPU strobe bus, VRAM arbiter handshake and register/status sideband of the VDP host port.
// The slave modport is the host port's view; master is the surrounding system's view.
interface vdp_host_if #(
    parameter int unsigned ADDR_W = 14
);
    logic [1:0]        mode;
    logic              read;
    logic              write;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              vram_req;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_ack;
    logic [7:0]        vram_rdata;
    logic              reg_we;
    logic [2:0]        reg_addr;
    logic [7:0]        reg_data;
    logic [7:0]        status_in;
    logic              status_rd;
    logic              overrun;

    modport slave (
        input  mode, read, write, data_in, vram_ack, vram_rdata, status_in,
        output data_out, vram_req, vram_we, vram_addr, vram_wdata,
        output reg_we, reg_addr, reg_data, status_rd, overrun
    );

    modport master (
        output mode, read, write, data_in, vram_ack, vram_rdata, status_in,
        input  data_out, vram_req, vram_we, vram_addr, vram_wdata,
        input  reg_we, reg_addr, reg_data, status_rd, overrun
    );
endinterface

// File: rtl/vdp_host_port.sv
// VDP CPU host port: decodes strobe accesses into auto-incrementing VRAM transactions,
// register writes and status reads, with a one-deep outstanding VRAM request.
module vdp_host_port #(
    parameter int unsigned ADDR_W = 14
) (
    input logic       clk,
    input logic       reset,
    vdp_host_if.slave bus
);
    logic              read_q, write_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rbuf_q, rbuf_d;
    logic [7:0]        latch_q, latch_d;
    logic              second_q, second_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              reg_we_q, reg_we_d;
    logic [2:0]        reg_addr_q, reg_addr_d;
    logic [7:0]        reg_data_q, reg_data_d;
    logic              status_rd_q, status_rd_d;

    logic              wr_edge, rd_edge, busy;
    logic [ADDR_W-1:0] ctrl_addr;

    // A simultaneous read and write edge is treated as a write only.
    assign wr_edge   = bus.write & ~write_q;
    assign rd_edge   = bus.read & ~read_q & ~wr_edge;
    assign busy      = req_q;
    assign ctrl_addr = {bus.data_in[ADDR_W-9:0], latch_q};

    always_comb begin
        addr_d      = addr_q;
        rbuf_d      = rbuf_q;
        latch_d     = latch_q;
        second_d    = second_q;
        overrun_d   = overrun_q;
        data_out_d  = data_out_q;
        req_d       = req_q;
        we_d        = we_q;
        vaddr_d     = vaddr_q;
        wdata_d     = wdata_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        status_rd_d = 1'b0;

        // Ack retires the transaction; a new access in this same cycle still sees busy.
        if (req_q && bus.vram_ack) begin
            req_d = 1'b0;
            if (!we_q) begin
                rbuf_d = bus.vram_rdata;
            end
        end

        unique case (bus.mode)
            2'd0: begin
                if (wr_edge || rd_edge) begin
                    second_d = 1'b0;
                    if (rd_edge) begin
                        data_out_d = rbuf_q;
                    end
                    if (busy) begin
                        overrun_d = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = wr_edge;
                        vaddr_d = addr_q;
                        addr_d  = addr_q + ADDR_W'(1);
                        if (wr_edge) begin
                            wdata_d = bus.data_in;
                        end
                    end
                end
            end
            2'd1: begin
                if (rd_edge) begin
                    data_out_d = 8'hFF;
                end else if (wr_edge && !second_q) begin
                    latch_d  = bus.data_in;
                    second_d = 1'b1;
                end else if (wr_edge) begin
                    second_d = 1'b0;
                    case (bus.data_in[7:6])
                        2'b00: begin
                            if (busy) begin
                                overrun_d = 1'b1;
                            end else begin
                                req_d   = 1'b1;
                                we_d    = 1'b0;
                                vaddr_d = ctrl_addr;
                                addr_d  = ctrl_addr + ADDR_W'(1);
                            end
                        end
                        2'b01: addr_d = ctrl_addr;
                        2'b10: begin
                            reg_we_d   = 1'b1;
                            reg_addr_d = bus.data_in[2:0];
                            reg_data_d = latch_q;
                        end
                        default: ;
                    endcase
                end
            end
            2'd2: begin
                if (rd_edge) begin
                    data_out_d  = bus.status_in;
                    status_rd_d = 1'b1;
                    second_d    = 1'b0;
                    overrun_d   = 1'b0;
                end
            end
            default: begin
                if (rd_edge) begin
                    data_out_d = 8'hFF;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            rbuf_q      <= 8'h00;
            latch_q     <= 8'h00;
            second_q    <= 1'b0;
            overrun_q   <= 1'b0;
            data_out_q  <= 8'h00;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            vaddr_q     <= '0;
            wdata_q     <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= 3'd0;
            reg_data_q  <= 8'h00;
            status_rd_q <= 1'b0;
        end else begin
            read_q      <= bus.read;
            write_q     <= bus.write;
            addr_q      <= addr_d;
            rbuf_q      <= rbuf_d;
            latch_q     <= latch_d;
            second_q    <= second_d;
            overrun_q   <= overrun_d;
            data_out_q  <= data_out_d;
            req_q       <= req_d;
            we_q        <= we_d;
            vaddr_q     <= vaddr_d;
            wdata_q     <= wdata_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            status_rd_q <= status_rd_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.vram_req   = req_q;
    assign bus.vram_we    = we_q;
    assign bus.vram_addr  = vaddr_q;
    assign bus.vram_wdata = wdata_q;
    assign bus.reg_we     = reg_we_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_data   = reg_data_q;
    assign bus.status_rd  = status_rd_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_vdp_host_port.sv
// Bench for vdp_host_port: transaction-queue reference model compared every cycle,
// directed scenarios with literal expectations, then randomized CPU/arbiter traffic.
module tb_vdp_host_port;
    localparam int unsigned ADDR_W = 14;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vdp_host_if #(.ADDR_W(ADDR_W)) bus ();

    vdp_host_port #(.ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    bit auto_ack = 1'b0;

    // Reference model state
    txn_t        pend[$];
    int unsigned m_addr;
    logic [7:0]  m_rbuf, m_latch, m_dout, m_reg_data;
    logic [2:0]  m_reg_addr;
    bit          m_second, m_over, m_reg_we, m_stat, m_rq, m_wq;

    // Observed request log and pulse counters
    txn_t log_q[$];
    bit   prev_req = 1'b0;
    int   n_reg_we = 0;
    int   n_stat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic vram_op(input bit we, input int unsigned a, input logic [7:0] d,
                           input bit was_busy);
        txn_t t;
        if (was_busy) begin
            m_over = 1'b1;
        end else begin
            t.we = we;
            t.addr = ADDR_W'(a);
            t.data = d;
            pend.push_back(t);
            m_addr = (a + 1) % (1 << ADDR_W);
        end
    endtask

    task automatic model_step();
        bit          wr_e, rd_e, was_busy;
        int unsigned target;
        txn_t        t;
        if (!reset) begin
            pend.delete();
            m_addr = 0; m_rbuf = 0; m_latch = 0; m_dout = 0; m_reg_data = 0; m_reg_addr = 0;
            m_second = 0; m_over = 0; m_reg_we = 0; m_stat = 0; m_rq = 0; m_wq = 0;
            return;
        end
        wr_e = bus.write && !m_wq;
        rd_e = bus.read && !m_rq && !wr_e;
        m_wq = bus.write;
        m_rq = bus.read;
        was_busy = pend.size() != 0;
        m_reg_we = 0;
        m_stat = 0;
        if (wr_e || rd_e) begin
            case (bus.mode)
                2'd0: begin
                    m_second = 0;
                    if (rd_e) m_dout = m_rbuf;
                    vram_op(wr_e, m_addr, bus.data_in, was_busy);
                end
                2'd1: begin
                    if (rd_e) begin
                        m_dout = 8'hFF;
                    end else if (!m_second) begin
                        m_latch = bus.data_in;
                        m_second = 1;
                    end else begin
                        m_second = 0;
                        target = ((int'(bus.data_in) % (1 << (ADDR_W - 8))) * 256) + int'(m_latch);
                        case (bus.data_in[7:6])
                            2'b00: vram_op(1'b0, target, 8'h00, was_busy);
                            2'b01: m_addr = target;
                            2'b10: begin
                                m_reg_we = 1;
                                m_reg_addr = bus.data_in[2:0];
                                m_reg_data = m_latch;
                            end
                            default: ;
                        endcase
                    end
                end
                2'd2: begin
                    if (rd_e) begin
                        m_dout = bus.status_in;
                        m_stat = 1;
                        m_second = 0;
                        m_over = 0;
                    end
                end
                default: if (rd_e) m_dout = 8'hFF;
            endcase
        end
        if (was_busy && bus.vram_ack) begin
            t = pend.pop_front();
            if (!t.we) m_rbuf = bus.vram_rdata;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle compare against the model, plus request/pulse logging
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("data_out", bus.data_out, m_dout);
                chk("vram_req", bus.vram_req, pend.size() != 0);
                if (pend.size() != 0) begin
                    chk("vram_we", bus.vram_we, pend[0].we);
                    chk("vram_addr", bus.vram_addr, pend[0].addr);
                    if (pend[0].we) chk("vram_wdata", bus.vram_wdata, pend[0].data);
                end
                chk("reg_we", bus.reg_we, m_reg_we);
                chk("reg_addr", bus.reg_addr, m_reg_addr);
                chk("reg_data", bus.reg_data, m_reg_data);
                chk("status_rd", bus.status_rd, m_stat);
                chk("overrun", bus.overrun, m_over);
            end
            if (bus.vram_req === 1'b1 && !prev_req) begin
                t.we = bus.vram_we;
                t.addr = bus.vram_addr;
                t.data = bus.vram_wdata;
                log_q.push_back(t);
            end
            prev_req = (bus.vram_req === 1'b1);
            if (bus.reg_we === 1'b1) n_reg_we++;
            if (bus.status_rd === 1'b1) n_stat++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            bus.vram_ack = ($urandom_range(0, 2) == 0);
            bus.vram_rdata = 8'($urandom);
            bus.status_in = 8'($urandom);
        end
    endtask

    task automatic access(input bit wr, input logic [1:0] md, input logic [7:0] d);
        tick();
        bus.mode = md;
        bus.data_in = d;
        if (wr) bus.write = 1'b1;
        else bus.read = 1'b1;
        tick();
        tick();
        bus.write = 1'b0;
        bus.read = 1'b0;
    endtask

    task automatic ack_now(input logic [7:0] d);
        tick();
        bus.vram_ack = 1'b1;
        bus.vram_rdata = d;
        tick();
        bus.vram_ack = 1'b0;
    endtask

    task automatic rand_access();
        int kind;
        kind = $urandom_range(0, 9);
        bus.mode = 2'($urandom_range(0, 3));
        bus.data_in = 8'($urandom);
        if (kind == 0) begin
            bus.read = 1'b1;
            bus.write = 1'b1;
        end else if (kind < 5) begin
            bus.write = 1'b1;
        end else begin
            bus.read = 1'b1;
        end
        repeat ($urandom_range(2, 3)) tick();
        bus.read = 1'b0;
        bus.write = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
    endtask

    initial begin
        int n0, r0, s0;
        txn_t t;

        // Reset with strobes and a stray ack active
        bus.mode = 2'd0; bus.read = 1'b1; bus.write = 1'b1; bus.data_in = 8'h5C;
        bus.vram_ack = 1'b1; bus.vram_rdata = 8'hEE; bus.status_in = 8'h00;
        reset = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        tick();
        chk("rst_data_out", bus.data_out, 8'h00);
        chk("rst_vram_req", bus.vram_req, 1'b0);
        chk("rst_vram_we", bus.vram_we, 1'b0);
        chk("rst_vram_addr", bus.vram_addr, 14'h0000);
        chk("rst_vram_wdata", bus.vram_wdata, 8'h00);
        chk("rst_overrun", bus.overrun, 1'b0);
        chk("rst_reg_we", bus.reg_we | bus.status_rd, 1'b0);
        bus.read = 1'b0; bus.write = 1'b0; bus.vram_ack = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Address set with prefetch at 0x1234, then a data-port read
        n0 = log_q.size();
        access(1'b1, 2'd1, 8'h34);
        access(1'b1, 2'd1, 8'h12);
        tick();
        ack_now(8'hA5);
        chk("prefetch_count", log_q.size() - n0, 1);
        t = log_q[log_q.size() - 1];
        chk("prefetch_addr", t.addr, 14'h1234);
        chk("prefetch_we", t.we, 1'b0);
        chk("model_rbuf", m_rbuf, 8'hA5);
        access(1'b0, 2'd0, 8'h00);
        chk("read_data", bus.data_out, 8'hA5);
        t = log_q[log_q.size() - 1];
        chk("read_addr", t.addr, 14'h1235);
        ack_now(8'h3C);

        // Register write: no VRAM traffic
        n0 = log_q.size();
        r0 = n_reg_we;
        access(1'b1, 2'd1, 8'h07);
        access(1'b1, 2'd1, 8'h83);
        tick();
        chk("reg_pulses", n_reg_we - r0, 1);
        chk("reg_addr_lit", bus.reg_addr, 3'd3);
        chk("reg_data_lit", bus.reg_data, 8'h07);
        chk("reg_no_vram", log_q.size() - n0, 0);

        // Address wrap from 0x3FFF
        access(1'b1, 2'd1, 8'hFF);
        access(1'b1, 2'd1, 8'h7F);
        chk("model_addr_3fff", m_addr, 32'h3FFF);
        access(1'b1, 2'd0, 8'h11);
        ack_now(8'h00);
        access(1'b1, 2'd0, 8'h22);
        ack_now(8'h00);
        t = log_q[log_q.size() - 2];
        chk("wrap_addr0", t.addr, 14'h3FFF);
        chk("wrap_data0", t.data, 8'h11);
        t = log_q[log_q.size() - 1];
        chk("wrap_addr1", t.addr, 14'h0000);
        chk("wrap_data1", t.data, 8'h22);
        chk("wrap_we1", t.we, 1'b1);

        // Overrun while ack withheld, cleared by a status read
        n0 = log_q.size();
        access(1'b1, 2'd0, 8'h55);
        access(1'b1, 2'd0, 8'h66);
        chk("overrun_set", bus.overrun, 1'b1);
        chk("overrun_one_req", log_q.size() - n0, 1);
        ack_now(8'h00);
        bus.status_in = 8'h5A;
        s0 = n_stat;
        access(1'b0, 2'd2, 8'h00);
        chk("status_data", bus.data_out, 8'h5A);
        chk("status_pulses", n_stat - s0, 1);
        chk("overrun_clear", bus.overrun, 1'b0);

        // Status read restarts the control-port byte toggle
        n0 = log_q.size();
        access(1'b1, 2'd1, 8'hAB);
        access(1'b0, 2'd2, 8'h00);
        access(1'b1, 2'd1, 8'h00);
        access(1'b1, 2'd1, 8'h40);
        tick();
        chk("toggle_no_prefetch", log_q.size() - n0, 0);
        chk("model_addr_0", m_addr, 0);
        access(1'b1, 2'd0, 8'h77);
        t = log_q[log_q.size() - 1];
        chk("toggle_addr", t.addr, 14'h0000);
        chk("toggle_data", t.data, 8'h77);
        ack_now(8'h00);

        // Randomized traffic with random acks and occasional resets
        auto_ack = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 75) begin
                reset = 1'b0;
                bus.read = 1'($urandom);
                bus.write = 1'($urandom);
                tick();
                tick();
                bus.read = 1'b0;
                bus.write = 1'b0;
                reset = 1'b1;
                tick();
            end
            rand_access();
        end
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
